// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam int DATA_BITS = 8;

  function automatic int bit_clks(input int half);
    return 2 * half;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Register-array FIFO with the head shown combinationally on rdata and a sticky overflow flag.
module uart_tx_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wdata,
  input  logic          rd_en,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf
);

  localparam logic [AW:0] DEPTH = (AW + 1)'(2 ** AW);

  logic [W-1:0] mem [2 ** AW];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_wr;
  logic         do_rd;

  // Flags come from pre-edge pointers, so a push while full is refused even if a pop happens on the same edge.
  assign count = wptr - rptr;
  assign full  = (count == DEPTH);
  assign empty = (wptr == rptr);
  assign rdata = mem[rptr[AW-1:0]];
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      if (wr_en && full) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed from a small FIFO; frames go back to back while bytes are queued.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int FIFO_AW          = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         sdata,
  input  logic               tx_start,
  output logic               full,
  output logic               tx_busy,
  output logic               ovf,
  output logic [FIFO_AW:0]   count,
  output logic               txd
);

  localparam int          BIT_CLKS = bit_clks(CLK_PER_HALF_BIT);
  localparam logic [31:0] LAST_CLK = 32'(BIT_CLKS - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t  state;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  head;
  logic        empty;
  logic        expire;
  logic        pop;

  uart_tx_fifo #(
    .W  (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (tx_start),
    .wdata (sdata),
    .rd_en (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count),
    .ovf   (ovf)
  );

  assign expire  = (cnt == LAST_CLK);
  assign pop     = !empty && ((state == TX_IDLE) || (state == TX_STOP && expire));
  assign tx_busy = (state != TX_IDLE) || !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          cnt <= '0;
          if (pop) begin
            shreg <= head;
            txd   <= 1'b0;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (expire) begin
            cnt     <= '0;
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= TX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (expire) begin
            cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (expire) begin
            cnt <= '0;
            if (pop) begin
              shreg <= head;
              txd   <= 1'b0;
              state <= TX_START;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= TX_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed and random stimulus against a frame-timeline model of the buffered UART transmitter.
module tb_uart_tx_buffered;

  localparam int HALF  = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int BITC  = 8;
  localparam int FRAME = 10 * BITC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    sdata = 8'h00;
  logic          tx_start = 1'b0;
  logic          full;
  logic          tx_busy;
  logic          ovf;
  logic [AW:0]   count;
  logic          txd;

  int checks = 0;
  int errors = 0;

  // Reference model: queued bytes, byte on the line, cycles left in its frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur = 8'h00;
  int         m_fl  = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] sent_q[$];
  logic [7:0] rx_q[$];

  bit         dec_active = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;

  uart_tx_buffered #(
    .CLK_PER_HALF_BIT (HALF),
    .FIFO_AW          (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sdata    (sdata),
    .tx_start (tx_start),
    .full     (full),
    .tx_busy  (tx_busy),
    .ovf      (ovf),
    .count    (count),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_txd();
    int pos;
    int b;
    if (m_fl == 0) return 1'b1;
    pos = FRAME - m_fl;
    b   = pos / BITC;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_txd"},   32'(txd),     32'(exp_txd()));
    chk({tag, "_count"}, 32'(count),   32'(m_q.size()));
    chk({tag, "_full"},  32'(full),    32'(m_q.size() == DEPTH));
    chk({tag, "_busy"},  32'(tx_busy), 32'(m_fl > 0 || m_q.size() > 0));
    chk({tag, "_ovf"},   32'(ovf),     32'(m_ovf));
  endtask

  task automatic decode();
    if (!dec_active) begin
      if (txd === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % BITC == BITC / 2 && dec_cnt / BITC >= 1 && dec_cnt / BITC <= 8)
        dec_byte[dec_cnt / BITC - 1] = txd;
      if (dec_cnt == FRAME - 1) begin
        rx_q.push_back(dec_byte);
        dec_active = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, sample 1 time unit later.
  task automatic cycle(input logic st, input logic [7:0] d, input string tag);
    bit accept;
    bit do_pop;
    tx_start = st;
    sdata    = st ? d : 8'hxx;
    @(posedge clk);
    accept = st && (m_q.size() < DEPTH);
    do_pop = (m_q.size() > 0) && (m_fl <= 1);
    if (do_pop) begin
      m_cur = m_q.pop_front();
      m_fl  = FRAME;
    end else if (m_fl > 0) begin
      m_fl--;
    end
    if (accept) begin
      m_q.push_back(d);
      sent_q.push_back(d);
    end else if (st) begin
      m_ovf = 1'b1;
    end
    #1;
    check_outputs(tag);
    decode();
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, tag);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // 1: single byte while idle
    cycle(1'b1, 8'h55, "t1");
    idle(FRAME + 8, "t1");

    // 2: two back-to-back frames
    cycle(1'b1, 8'hA3, "t2");
    cycle(1'b1, 8'h0F, "t2");
    idle(2 * FRAME + 8, "t2");

    // 3: fill past capacity, sixth push dropped
    for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i), "t3");
    chk("t3_ovf_sticky", 32'(ovf), 32'd1);
    idle(5 * FRAME + 8, "t3");

    // 4: pushes around the STOP->START pop edge
    cycle(1'b1, 8'hC1, "t4");
    cycle(1'b1, 8'hC2, "t4");
    for (int i = 0; i < 2 * FRAME && m_fl != 3; i++) cycle(1'b0, 8'h00, "t4w");
    chk("t4_reached_stop", 32'(m_fl), 32'd3);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hD0 + 8'(i), "t4");
    idle(6 * FRAME + 8, "t4");

    // 5: async reset mid-DATA with bytes queued
    cycle(1'b1, 8'hFF, "t5");
    cycle(1'b1, 8'h11, "t5");
    cycle(1'b1, 8'h22, "t5");
    idle(30, "t5");
    rst = 1'b1;
    #1;
    chk("t5_async_txd",   32'(txd),     32'd1);
    chk("t5_async_count", 32'(count),   32'd0);
    chk("t5_async_ovf",   32'(ovf),     32'd0);
    chk("t5_async_busy",  32'(tx_busy), 32'd0);
    m_q.delete();
    m_fl = 0;
    m_ovf = 1'b0;
    dec_active = 1'b0;
    while (sent_q.size() > rx_q.size()) void'(sent_q.pop_back());
    @(posedge clk);
    #1;
    check_outputs("t5_rst");
    rst = 1'b0;
    cycle(1'b1, 8'h81, "t5b");
    idle(FRAME + 8, "t5b");

    // 6: random bytes with random gaps
    for (int i = 0; i < 64; i++) begin
      idle(int'($urandom_range(0, 100)), "t6");
      cycle(1'b1, 8'($urandom), "t6");
    end
    for (int i = 0; i < 100 * FRAME && (m_fl > 0 || m_q.size() > 0); i++)
      cycle(1'b0, 8'h00, "t6d");
    chk("t6_drained", 32'(m_fl > 0 || m_q.size() > 0), 32'd0);
    idle(4, "t6");

    // Decoded line stream versus accepted pushes
    chk("stream_len", 32'(rx_q.size()), 32'(sent_q.size()));
    for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++)
      chk("stream_byte", 32'(rx_q[i]), 32'(sent_q[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
